// File: rtl/seg_scan_driver.sv
// seg_scan_driver: double-buffered, time-multiplexed N-digit hex seven-segment driver; define SEG_LZ_BLANK_EN for leading-zero blanking
module seg_scan_driver #(
  parameter int DIGITS = 6,
  parameter int PRESCALE = 50000,
  parameter int DEADTIME = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  enable,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     dig_out,
  output logic                  frame_tick,
  output logic                  pending
);
  localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW != 0 ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW != 0 ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [CW-1:0] slot_cnt, cnt_n;
  logic [DIGITS-1:0][3:0] disp_val, disp_val_n, pend_val, pend_val_n;
  logic [DIGITS-1:0] disp_dp, disp_dp_n, pend_dp, pend_dp_n, blank_n;
  logic pending_n, entry, direct;
  logic [7:0] seg_n;
  logic [DIGITS-1:0] dig_n;
`ifdef SEG_LZ_BLANK_EN
  logic zero_above;
  // blank every digit above the highest nonzero one of the display value being applied; digit 0 always shows
  always_comb begin
    blank_n = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && disp_val_n[i] == 4'd0;
      blank_n[i] = zero_above;
    end
  end
`else
  assign blank_n = '0;
`endif
  // scan sequencing, frame-start buffer swap and next output values
  always_comb begin
    state_n = !enable ? IDLE
            : state == IDLE ? BLANK
            : state == BLANK && slot_cnt == CW'(DEADTIME - 1) ? ON
            : state == ON && slot_cnt == CW'(PRESCALE - 1) ? BLANK
            : state;
    cnt_n = state_n == IDLE || (state_n == BLANK && state != BLANK) ? '0 : slot_cnt + 1'b1;
    idx_n = state == IDLE ? '0
          : state == ON && state_n == BLANK ? (idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1)
          : idx;
    entry = state_n == BLANK && state != BLANK && idx_n == '0;
    direct = load && (state == IDLE || frame_tick || entry);
    disp_val_n = direct ? value_in : entry && pending ? pend_val : disp_val;
    disp_dp_n = direct ? dp_in : entry && pending ? pend_dp : disp_dp;
    pend_val_n = load && !direct ? value_in : pend_val;
    pend_dp_n = load && !direct ? dp_in : pend_dp;
    pending_n = entry ? 1'b0 : load && !direct ? 1'b1 : pending;
    seg_n = state_n == IDLE ? 8'h00 : {disp_dp_n[idx_n], blank_n[idx_n] ? 7'h00 : DEC[disp_val_n[idx_n]]};
    dig_n = state_n == ON ? DIGITS'(1) << idx_n : '0;
  end
  // state, buffers and registered pin outputs; reset darkens the pins without waiting for a clock
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state <= IDLE;
      idx <= '0;
      slot_cnt <= '0;
      disp_val <= '0;
      disp_dp <= '0;
      pend_val <= '0;
      pend_dp <= '0;
      pending <= 1'b0;
      frame_tick <= 1'b0;
      seg_out <= SEG_OFF;
      dig_out <= DIG_OFF;
    end else begin
      state <= state_n;
      idx <= idx_n;
      slot_cnt <= cnt_n;
      disp_val <= disp_val_n;
      disp_dp <= disp_dp_n;
      pend_val <= pend_val_n;
      pend_dp <= pend_dp_n;
      pending <= pending_n;
      frame_tick <= entry;
      seg_out <= seg_n ^ SEG_OFF;
      dig_out <= dig_n ^ DIG_OFF;
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench for seg_scan_driver with DIGITS=6, PRESCALE=8, DEADTIME=2, active-low pins
module tb_seg_scan_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [23:0] value = '0;
  logic [5:0] dp = '0;
  logic load = 1'b0;
  logic enable = 1'b0;
  logic [7:0] seg;
  logic [5:0] dig;
  logic tick, pend;
  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q [$];
  logic [13:0] mon_e;
  logic [5:0] prev_dig = 6'h3F;
`ifdef SEG_LZ_BLANK_EN
  localparam logic [7:0] Z = 8'hFF;
  localparam logic [7:0] D2 = 8'h7F;
`else
  localparam logic [7:0] Z = 8'hC0;
  localparam logic [7:0] D2 = 8'h40;
`endif

  seg_scan_driver #(.DIGITS(6), .PRESCALE(8), .DEADTIME(2), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .value_in(value), .dp_in(dp), .load(load), .enable(enable),
    .seg_out(seg), .dig_out(dig), .frame_tick(tick), .pending(pend));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] s0, s1, s2, s3, s4, s5, input int n);
    logic [7:0] s [6];
    s = '{s0, s1, s2, s3, s4, s5};
    for (int k = 0; k < n; k++) exp_q.push_back({6'h3F & ~(6'd1 << k), s[k]});
  endtask

  // each digit-on start must match the next expected {dig, seg} in the scoreboard
  always @(negedge clk) begin
    if (rst_n && prev_dig == 6'h3F && dig != 6'h3F) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scan_slot: unexpected dig %h seg %h", dig, seg);
      end else begin
        mon_e = exp_q.pop_front();
        if ({dig, seg} !== mon_e) begin
          errors++;
          $display("FAIL scan_slot: got dig %h seg %h expected dig %h seg %h", dig, seg, mon_e[13:8], mon_e[7:0]);
        end
      end
    end
    prev_dig <= dig;
  end

  task automatic step_load(input logic [23:0] v, input logic [5:0] d);
    value = v;
    dp = d;
    load = 1'b1;
  endtask

  // walk one frame from its tick cycle (i=0) to cycle 'last', applying per-frame stimulus
  task automatic run_frame(input int f, input int last);
    for (int i = 0; i <= last; i++) begin
      load = 1'b0;
      if (i == 0) check($sformatf("frame%0d_tick", f), tick, 1);
      if (f == 1) begin
        check("scan_dig", dig, (i % 8 < 2) ? 6'h3F : 6'h3F & ~(6'd1 << (i / 8)));
        if (i > 0) check("tick_low", tick, 0);
      end
      if (f == 2 && i == 18) step_load(24'h00000A, 6'h00);
      if (f == 2 && (i == 20 || i == 47)) check("mid_load_pending", pend, 1);
      if (f == 3 && i == 0) check("swap_pending_clear", pend, 0);
      if (f == 3 && i == 10) step_load(24'h000009, 6'h00);
      if (f == 3 && i == 12) check("old_pend_waiting", pend, 1);
      if (f == 4 && i == 0) step_load(24'h000001, 6'h00);
      if (f == 4 && i == 2) check("tick_load_pending", pend, 0);
      if (f == 4 && i == 20) step_load(24'h000003, 6'h00);
      if (f == 4 && i == 30) step_load(24'h000005, 6'h00);
      if (f == 4 && i == 32) check("double_load_pending", pend, 1);
      if (f == 5 && i == 0) check("double_load_applied", pend, 0);
      if (f == 5 && i == 5) step_load(24'h00002F, 6'b000100);
      if (f == 6 && i == 1) check("lz_load_applied", pend, 0);
      if (f == 6 && i == 20) enable = 1'b0;
      if (f == 6 && i == 21) begin
        check("disable_dig", dig, 6'h3F);
        check("disable_seg", seg, 8'hFF);
      end
      if (f == 8 && i == 27) check("digit3_on", dig, 6'h37);
      if (i < last || f != 8) @(negedge clk);
    end
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("reset_seg", seg, 8'hFF);
    check("reset_dig", dig, 6'h3F);
    check("reset_tick", tick, 0);
    check("reset_pending", pend, 0);
    rst_n = 1'b1;
    @(negedge clk);
    step_load(24'h123456, 6'h00);
    @(negedge clk);
    load = 1'b0;
    check("idle_pending", pend, 0);
    check("idle_seg", seg, 8'hFF);
    check("idle_dig", dig, 6'h3F);
    push_frame(8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 6);
    push_frame(8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 6);
    push_frame(8'h88, Z, Z, Z, Z, Z, 6);
    push_frame(8'hF9, Z, Z, Z, Z, Z, 6);
    push_frame(8'h92, Z, Z, Z, Z, Z, 6);
    push_frame(8'h8E, 8'hA4, D2, Z, Z, Z, 3);
    enable = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (tick !== 1'b1 && k < 10);
    check("enable_latency", k, 1);
    for (int f = 1; f <= 5; f++) run_frame(f, 47);
    run_frame(6, 21);
    step_load(24'h000007, 6'h00);
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    check("dark_dig", dig, 6'h3F);
    check("dark_seg", seg, 8'hFF);
    check("dark_tick", tick, 0);
    check("dark_pending", pend, 0);
    push_frame(8'hF8, Z, Z, Z, Z, Z, 6);
    push_frame(8'hF8, Z, Z, Z, Z, Z, 4);
    enable = 1'b1;
    @(negedge clk);
    run_frame(7, 47);
    run_frame(8, 27);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_seg", seg, 8'hFF);
    check("async_reset_dig", dig, 6'h3F);
    check("async_reset_pending", pend, 0);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised time-multiplexed seven-segment display driver for the SoC's display path. It replaces the fixed six-digit, 24-bit static `seg6` PIO export with a block that does the following:

- takes an N-digit hex value from a PIO, with a load strobe
- double-buffers it so a frame never tears
- hex-decodes each digit
- scans the digits one at a time with a programmable slot time and dead time
- provides an optional leading-zero blanking feature

It sits between the PIO export and the board's segment/digit pins.

## Interface
Parameters:
- `DIGITS`, 6: number of digits scanned, 1..16.
- `PRESCALE`, 50000: `clk_clk` cycles per digit slot; must be greater than `DEADTIME`.
- `DEADTIME`, 16: cycles per slot with all digits off (ghosting guard), ≥1.
- `SEG_ACTIVE_LOW`, 1: 1 inverts `seg_out`.
- `DIG_ACTIVE_LOW`, 1: 1 inverts `dig_out`.

Ports:
- `clk_clk`  in  1  sole clock.
- `reset_reset_n`  in  1  asynchronous, active-low reset.
- `value_in`  in  4*DIGITS  hex digits; digit i = `[4i+3:4i]`; digit 0 is rightmost.
- `dp_in`  in  DIGITS  decimal point per digit, 1 = lit.
- `load`  in  1  one-cycle strobe that captures `value_in`/`dp_in`.
- `enable`  in  1  1 = scanning; 0 = display dark.
- `seg_out`  out  8  `{dp,g,f,e,d,c,b,a}`, polarity per `SEG_ACTIVE_LOW`.
- `dig_out`  out  DIGITS  one-hot digit select, polarity per `DIG_ACTIVE_LOW`.
- `frame_tick`  out  1  one-cycle pulse at each frame start.
- `pending`  out  1  a loaded value is waiting for the next frame start.

## Operation
Registers:
- `disp`: display register, 5*DIGITS bits.
- `pend`: pending register, 5*DIGITS bits.
- `pending` flag.
- `idx`: digit index.
- `slot_cnt`: `$clog2(PRESCALE)` bits.
- `state`: one of IDLE, BLANK, ON.

State machine:
- **IDLE:**
  - All digits off and all segments off.
  - `load` writes `disp` directly; `pending` stays 0.
  - `enable`=1 moves to BLANK with `idx`=0 and `slot_cnt`=0.
- **BLANK:**
  - `dig_out` all off; `seg_out` is pre-driven with the decode of `disp[idx]`.
  - After `DEADTIME` cycles, go to ON.
- **ON:**
  - `dig_out` selects `idx`; `seg_out` = decode of `disp[idx]`.
  - After `PRESCALE-DEADTIME` cycles, go to BLANK with `idx` = `idx+1`, wrapping `DIGITS-1` to 0.
- **Any state:** `enable`=0 goes to IDLE on the next edge. `pending` and `pend` are kept.

Frame start:
- Definition: the cycle of entry into BLANK with `idx`=0, including the first entry from IDLE.
- `frame_tick`=1 for that cycle.
- If `pending`=1, `disp` ← `pend` and `pending` ← 0.

Load handling while scanning:
- `load` writes `pend` and sets `pending`=1. A second `load` before the frame start overwrites `pend`; last value wins.
- `load` in the frame-start cycle itself: that cycle's `value_in`/`dp_in` goes straight to `disp` and `pending` stays 0.

Decode (active-high, before polarity inversion), 0..F:
- 0..7: 3F 06 5B 4F 66 6D 7D 07
- 8..F: 7F 6F 77 7C 39 5E 79 71
- dp bit 7 = `dp_in` bit for that digit.

## Timing
- All outputs are registered.
- Reset (asynchronous) values:
  - `state`=IDLE; `disp`, `pend`, `idx`, `slot_cnt` all 0.
  - `seg_out` all off (8'hFF when active-low).
  - `dig_out` all off.
  - `frame_tick`=0, `pending`=0.
- Reset asserted mid-scan forces the outputs off immediately, with no clock edge needed.
- `enable` 0→1: the first BLANK cycle is visible at the outputs 1 cycle later.
- Slot length = `PRESCALE` cycles. Frame length = `DIGITS*PRESCALE` cycles.
- Load-to-visible latency while scanning: at most one frame plus `DEADTIME+1` cycles.
- `enable` 1→0: outputs are dark 1 cycle later.

## Configuration
Macro `SEG_LZ_BLANK_EN`:
- **Defined:** at frame start, the block computes the highest nonzero digit h of the newly applied `disp`.
  - Digits above h show all segments a–g off; their dp is still honoured.
  - Digit 0 is always shown, so a value of 0 displays "0".
  - The blank mask is registered with `disp` and changes only at frame start.
- **Undefined:** every digit is always decoded. No mask logic is present.

## Test plan
Bench parameters: `DIGITS`=6, `PRESCALE`=8, `DEADTIME`=2, both polarities active-low.

1. **Reset mid-scan.** Drop `reset_reset_n` while in ON with digit 3 lit → `seg_out`=FF and `dig_out`=3F before the next edge; `pending`=0.
2. **Scan order.** `load` 0x123456 in IDLE, then `enable`=1 → per 8-cycle slot: 2 cycles `dig_out`=3F, then 6 cycles of 3E, 3D, 3B, 37, 2F, 1F in turn. `seg_out` in the ON cycles = ~{7D,6D,66,4F,5B,06}. `frame_tick` every 48 cycles.
3. **Load mid-frame.** `load` 0x00000A at slot 2 → `pending`=1 and the display is unchanged. At the next `frame_tick`, `pending`=0 and digit 0 shows ~77.
4. **Simultaneous events.**
   - `load` 0x000001 exactly on the `frame_tick` cycle, with an older pend 0x000009 waiting → digit 0 shows ~06 that frame; `pending`=0.
   - Two loads in one frame → only the last value appears.
5. **Leading-zero blanking.** Value 0x00002F with dp 000100:
   - `SEG_LZ_BLANK_EN` defined → digits 5,4,3 show FF; digit 2 shows 7F (dp only); digits 1,0 show ~5B, ~71.
   - Macro undefined → digits 5..2 show ~3F, with dp on digit 2.
6. **Disable and re-enable.** `enable`=0 mid-frame → dark 1 cycle later. `load` 0x000007 while dark → `disp` is updated directly. Re-enable → digit 0 shows ~07 in the first frame, and `frame_tick` fires on the first BLANK cycle.
